// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   XLEN            - data/address width of the attached dmem
//   PORT_CORE/AUX   - port ids (core datapath = 0, loader/debug = 1)
//   state_t         - response FSM encoding (IDLE / RESP)
package dmem_arb_pkg;

    localparam int XLEN = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,   // no response pending
        RESP = 1'b1    // a response is presented this cycle
    } state_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-requester grant logic for dmem_arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin (a 1-bit preferred-port
// pointer lives here); otherwise port 0 has fixed priority and no flop exists.
// Ports:
//   clk, rst  - clock / asynchronous active-high reset (pointer only)
//   valid     - per-port request valid
//   advance   - an acceptance happened this cycle
//   grant     - one-hot grant (zero when nothing is valid)
import dmem_arb_pkg::*;

module arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    logic ptr;

    // After an acceptance, prefer the port that did not just win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= PORT_CORE;
        else if (advance)
            ptr <= grant[0];
    end

    assign grant[0] = valid[0] & (~valid[1] | (ptr == PORT_CORE));
    assign grant[1] = valid[1] & (~valid[0] | (ptr == PORT_AUX));
`else
    logic unused_rr;
    assign unused_rr = clk ^ rst ^ advance;

    assign grant[0] = valid[0];
    assign grant[1] = valid[1] & ~valid[0];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous dmem between the core
// (port 0) and an auxiliary master (port 1). One request is issued per
// cycle; its response appears in the following cycle.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration.
// Handshake: a request is accepted in any cycle where req_valid[i] and
// req_ready[i] are both high; the losing port holds valid and its fields
// stable until accepted. Responses are a one-cycle resp_valid strobe with
// no backpressure; resp_err and resp_rdata are qualified by resp_valid.
// Ports:
//   clk, rst                   - clock / asynchronous active-high reset
//   req_valid/ready/we [1:0]   - per-port request handshake and store flag
//   req_addr0/1, req_wdata0/1  - per-port word address and store data
//   resp_valid [1:0], resp_err - response strobe per port, out-of-range flag
//   resp_rdata                 - load data (zero for stores and errors)
//   mem_addr/wdata/we          - to dmem
//   mem_rdata                  - from dmem (registered read data)
//   dbg_state                  - response FSM state
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter longint unsigned SIZE = 64'd1 << XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [XLEN-1:0] req_addr0,
    input  logic [XLEN-1:0] req_addr1,
    input  logic [XLEN-1:0] req_wdata0,
    input  logic [XLEN-1:0] req_wdata1,
    output logic [1:0]      resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output state_t          dbg_state
);

    logic [1:0]      grant;
    logic            any_grant;
    logic            sel;
    logic [XLEN-1:0] addr_sel;
    logic [XLEN-1:0] wdata_sel;
    logic            we_sel;
    logic            in_range;

    state_t state, state_next;
    logic   resp_id_q;
    logic   is_read_q;
    logic   err_q;

    // Nothing is granted while reset is held.
    arb_rr2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid & {2{~rst}}),
        .advance (any_grant),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;
    assign sel       = grant[1];
    assign addr_sel  = sel ? req_addr1  : req_addr0;
    assign wdata_sel = sel ? req_wdata1 : req_wdata0;
    assign we_sel    = sel ? req_we[1]  : req_we[0];
    assign in_range  = 64'(addr_sel) < SIZE;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (any_grant) begin
            mem_addr  = addr_sel;
            mem_wdata = wdata_sel;
            mem_we    = we_sel & in_range;
        end
    end

    // Response FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Response FSM: next state. Each acceptance yields exactly one response.
    always_comb begin
        state_next = any_grant ? RESP : IDLE;
    end

    // Captured response attributes; cleared when nothing was accepted so the
    // rdata mask and error flag are zero outside a response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_id_q <= PORT_CORE;
            is_read_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            resp_id_q <= sel;
            is_read_q <= any_grant & ~we_sel & in_range;
            err_q     <= any_grant & ~in_range;
        end
    end

    // Response FSM: outputs.
    always_comb begin
        resp_valid = 2'b00;
        if (state == RESP)
            resp_valid = (resp_id_q == PORT_AUX) ? 2'b10 : 2'b01;
        resp_err   = err_q;
        resp_rdata = is_read_q ? mem_rdata : '0;
        dbg_state  = state;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
import dmem_arb_pkg::*;

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b11;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b11;
    logic [31:0] req_addr0 = 32'd0;
    logic [31:0] req_addr1 = 32'd0;
    logic [31:0] req_wdata0 = 32'd0;
    logic [31:0] req_wdata1 = 32'd0;
    logic [1:0]  resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata = 32'd0;
    state_t      dbg_state;

    int total  = 0;
    int passed = 0;

    // clock / reset block
    always #5 clk = ~clk;

    dmem_arbiter #(.SIZE(64'd16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // 16-word synchronous dmem model (read-first, registered read data).
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr[3:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1);
        req_valid  = v;
        req_we     = we;
        req_addr0  = a0;
        req_wdata0 = d0;
        req_addr1  = a1;
        req_wdata1 = d1;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_g;
    logic [31:0] exp_d;

    initial begin
        // reset state, with both ports requesting stores
        #2;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // preload mem[0..4] through port 0, back-to-back stores
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 2'b01, 32'(i), 32'hC0DE_0000 | 32'(i), 32'd0, 32'd0);
            @(negedge clk);
            chk("pre_ready", 32'(req_ready), 32'd1);
            chk("pre_mem_we", 32'(mem_we), 32'd1);
            tick();
            chk("pre_resp_valid", 32'(resp_valid), 32'd1);
            chk("pre_resp_rdata", resp_rdata, 32'd0);
        end
        drive(2'b01, 2'b01, 32'd5, 32'hDEADBEEF, 32'd0, 32'd0);
        tick();
        idle();
        tick();
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_state", 32'(dbg_state), 32'(IDLE));

        // single read of address 5
        drive(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rd_ready", 32'(req_ready), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_addr", mem_addr, 32'd5);
        tick();
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_resp_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd_resp_err", 32'(resp_err), 32'd0);
        chk("rd_state", 32'(dbg_state), 32'(RESP));
        idle();
        tick();
        chk("rd_after_valid", 32'(resp_valid), 32'd0);

        // port 1 writes address 9, port 0 reads it the next cycle
        drive(2'b10, 2'b10, 32'd0, 32'd0, 32'd9, 32'h12345678);
        @(negedge clk);
        chk("wr1_ready", 32'(req_ready), 32'd2);
        chk("wr1_mem_we", 32'(mem_we), 32'd1);
        chk("wr1_mem_addr", mem_addr, 32'd9);
        chk("wr1_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        chk("wr1_resp_valid", 32'(resp_valid), 32'd2);
        chk("wr1_resp_rdata", resp_rdata, 32'd0);
        drive(2'b01, 2'b00, 32'd9, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("raw_ready", 32'(req_ready), 32'd1);
        tick();
        chk("raw_resp_valid", 32'(resp_valid), 32'd1);
        chk("raw_resp_rdata", resp_rdata, 32'h12345678);
        idle();
        tick();

        // asynchronous reset mid-cycle while a read response is pending
        drive(2'b01, 2'b00, 32'd2, 32'd0, 32'd0, 32'd0);
        tick();
        chk("pend_resp_valid", 32'(resp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_state", 32'(dbg_state), 32'(IDLE));
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_after1", 32'(resp_valid), 32'd0);
        tick();
        chk("arst_after2", 32'(resp_valid), 32'd0);

        // contention: both ports read continuously for 6 cycles
        drive(2'b11, 2'b00, 32'd0, 32'd0, 32'd1, 32'd0);
        for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            exp_d = exp_g[1] ? 32'hC0DE_0001 : 32'hC0DE_0000;
            @(negedge clk);
            chk("cont_ready", 32'(req_ready), 32'(exp_g));
            tick();
            chk("cont_resp_valid", 32'(resp_valid), 32'(exp_g));
            chk("cont_resp_rdata", resp_rdata, exp_d);
        end
        idle();
        tick();

        // out-of-range store to address 20 must not alias onto mem[4]
        drive(2'b01, 2'b01, 32'd20, 32'hFFFF_FFFF, 32'd0, 32'd0);
        @(negedge clk);
        chk("oor_ready", 32'(req_ready), 32'd1);
        chk("oor_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("oor_resp_valid", 32'(resp_valid), 32'd1);
        chk("oor_resp_err", 32'(resp_err), 32'd1);
        chk("oor_resp_rdata", resp_rdata, 32'd0);
        drive(2'b01, 2'b00, 32'd4, 32'd0, 32'd0, 32'd0);
        tick();
        chk("oor_mem4", resp_rdata, 32'hC0DE_0004);
        chk("oor_mem4_err", 32'(resp_err), 32'd0);
        // out-of-range load (address 16) returns zero with error
        drive(2'b01, 2'b00, 32'd16, 32'd0, 32'd0, 32'd0);
        tick();
        chk("oorrd_resp_err", 32'(resp_err), 32'd1);
        chk("oorrd_resp_rdata", resp_rdata, 32'd0);
        idle();
        tick();

        // back-to-back reads of addresses 0..3
        drive(2'b01, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_resp_valid", 32'(resp_valid), 32'd1);
            chk("b2b_resp_rdata", resp_rdata, 32'hC0DE_0000 | 32'(i));
            if (i < 3)
                drive(2'b01, 2'b00, 32'(i + 1), 32'd0, 32'd0, 32'd0);
            else
                idle();
            tick();
        end
        chk("b2b_end_valid", 32'(resp_valid), 32'd0);

        // final report
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`dmem`) between the core datapath (port 0) and a secondary master such as a program loader or debug unit (port 1). Each port uses a valid/ready request handshake and receives exactly one response one cycle after acceptance. The arbiter drives `dmem` directly and returns its synchronous read data to the winning port. At most one request is issued per cycle, and back-to-back requests are supported with no bubbles.

## Interface
Parameters:
- `SIZE`, default `(1 << XLEN)`: number of implemented `dmem` words. It must match the attached `dmem` instance.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-port request valid.
- `req_ready`  out  2  per-port grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `req_we`  in  2  per-port write enable (1 = store, 0 = load).
- `req_addr0`, `req_addr1`  in  XLEN  word address.
- `req_wdata0`, `req_wdata1`  in  XLEN  store data.
- `resp_valid`  out  2  one-cycle response strobe per port.
- `resp_err`  out  1  qualifies `resp_valid`: the address was out of range.
- `resp_rdata`  out  XLEN  load data, shared by both ports and qualified by `resp_valid`.
- `mem_addr`, `mem_wdata`  out  XLEN  to `dmem` `addr` / `wdata`.
- `mem_we`  out  1  to `dmem` `we`.
- `mem_rdata`  in  XLEN  from `dmem` `rdata`.

## Operation
- **Grant is combinational** from `req_valid` and the priority state.
  - At most one bit of `req_ready` is set per cycle.
  - `req_ready[i]` is 0 whenever `req_valid[i]` is 0.
- **Issue.** The granted port's address and data drive `mem_addr` and `mem_wdata` in the same cycle.
  - `mem_we = req_we[g] & in_range`, where `in_range = (req_addr < SIZE)`.
  - When nothing is granted: `mem_we = 0` and `mem_addr = 0`.
- **Out-of-range request.**
  - It is accepted, and nothing is written to `dmem`.
  - The response carries `resp_err = 1` and `resp_rdata = 0`.
- **Response registers.** On acceptance, these are captured: port id, `is_read = ~we & in_range`, and `err`.
  - In the next cycle, `resp_valid[id] = 1` for exactly one cycle.
  - `resp_rdata = is_read ? mem_rdata : 0`.
  - Write responses are acknowledgements only and always return `rdata = 0`.
- **No response backpressure.** Requesters must sink a response in the cycle it is presented.
- **Response FSM.** Two states: `IDLE` (no response pending) and `RESP` (response pending).
  - Any cycle with an acceptance moves to `RESP`.
  - A cycle with no acceptance moves to `IDLE`.
  - Back-to-back acceptances stay in `RESP` and deliver one response per cycle.
- **Simultaneous requests.** Resolved by the priority policy (see Configuration).
  - The losing port keeps `req_valid` high and holds its request fields stable until accepted.

## Timing
- **Latency.** A request accepted at edge N produces `resp_valid` during cycle N+1.
  - Throughput is one request per cycle, aggregate.
- **Outputs.**
  - `req_ready`, `mem_addr`, `mem_wdata` and `mem_we` are combinational from the inputs plus state.
  - `resp_*` are registered, except `resp_rdata`, which is a masked pass-through of `mem_rdata`.
- **Write visibility.** A write at edge N is visible to a read accepted at edge N+1 or later, from either port.
- **Read-after-write in consecutive cycles** returns the new data.
- **Reset values:** `resp_valid = 0`, `resp_err = 0`, the response FSM is in `IDLE`, and the priority pointer points to port 0.
  - With `rst` high, `req_ready = 0` and `mem_we = 0`.
- **Reset mid-operation.**
  - A pending response is dropped; no `resp_valid` follows.
  - A write whose edge occurred before `rst` rose remains committed.

## Configuration
- **With `DMEM_ARB_RR_EN` defined:** round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - After each acceptance, the pointer moves to the other port.
  - Neither port waits more than one cycle under contention.
- **Without it:** fixed priority, where port 0 always wins.
  - Port 1 can starve while port 0 is continuously valid.
  - The pointer flop is not built.

## Structure
- **`constants.vh` (existing include):** `XLEN`.
- **Shared package `dmem_arb_pkg`:**
  - port-id constants `PORT_CORE = 0` and `PORT_AUX = 1`;
  - FSM state encodings `IDLE` and `RESP`.
- **Sub-module `arb_rr2`:** the two-requester grant logic, with the pointer held inside under `DMEM_ARB_RR_EN`.
  - Inputs: `valid[1:0]`, `advance`.
  - Output: one-hot `grant[1:0]`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle while a read is pending -> `resp_valid = 0` immediately, and no response follows after release.
- **Single read:**
  - Preload `mem[5] = 32'hDEADBEEF`.
  - Port 0 reads address 5 -> `req_ready[0] = 1` at edge N.
  - Cycle N+1: `resp_valid = 2'b01` and `resp_rdata = 32'hDEADBEEF`.
- **Write then read across ports:**
  - Port 1 writes `32'h12345678` to address 9 at edge N; port 0 reads address 9 at edge N+1.
  - Cycle N+1: `resp_valid = 2'b10` with `rdata = 0`.
  - Cycle N+2: `resp_valid = 2'b01` with `resp_rdata = 32'h12345678`.
- **Contention:** both ports are continuously valid for 6 cycles.
  - With `DMEM_ARB_RR_EN`: grants alternate 0,1,0,1,0,1.
  - Without it: port 0 is granted all 6 cycles.
- **Out of range:** with `SIZE = 16`, port 0 writes address 20 -> `mem_we = 0`, then `resp_valid[0] = 1`, `resp_err = 1`, `resp_rdata = 0`, and `mem[4]` is unchanged.
- **Back-to-back:** port 0 issues 4 consecutive reads of addresses 0..3 -> four consecutive `resp_valid[0]` pulses with matching data and no bubbles.
